// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - byte-addressed data RAM controller with sub-word access and fixed-latency handshake
// Loads return extended data LATENCY cycles after accept; stores commit as the response retires.
module data_mem_ctrl #(
  parameter int DATA_W       = 64,
  parameter int DEPTH        = 128,
  parameter int LATENCY      = 2,
  parameter int INIT_PATTERN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [63:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [DEPTH-1:0][DATA_W-1:0] image_t;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  function automatic image_t init_image();
    image_t img;
    img = '0;
    if (INIT_PATTERN == 1) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == 10)      img[i] = DATA_W'(1540);
        else if (i == 11) img[i] = DATA_W'(2117);
        else              img[i] = DATA_W'(100 * i);
      end
    end
    return img;
  endfunction

  // Storage is deliberately outside the reset domain; contents survive reset.
  image_t mem = init_image();

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic              q_write;
  logic [1:0]        q_size;
  logic              q_signed;
  logic [63:0]       q_addr;
  logic [DATA_W-1:0] q_wdata;

  logic              accept;
  logic              enter_done;
  logic              src_write;
  logic [1:0]        src_size;
  logic              src_signed;
  logic [63:0]       src_addr;
  logic [DATA_W-1:0] src_wdata;

  logic [6:0]        nbits;
  logic [63:0]       idx_full;
  logic [IDX_W-1:0]  word_idx;
  logic [OFF_W-1:0]  off;
  logic [OFF_W+2:0]  sh_amt;
  logic              range_err, size_err, misaligned, dec_err;
  logic [DATA_W-1:0] rd_word, sh, mask, ld_val, wsh;
  logic              sign;
  logic [7:0]        lane, be;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign accept     = req_valid && req_ready;
  assign enter_done = (state_n == DONE) && (state != DONE);

  // With LATENCY=1 the response is formed on the accept edge, before the request registers load.
  always_comb begin
    if (state == IDLE) begin
      src_write  = req_write;
      src_size   = req_size;
      src_signed = req_signed;
      src_addr   = req_addr;
      src_wdata  = req_wdata;
    end else begin
      src_write  = q_write;
      src_size   = q_size;
      src_signed = q_signed;
      src_addr   = q_addr;
      src_wdata  = q_wdata;
    end
  end

  always_comb begin
    nbits     = 7'd8 << src_size;
    idx_full  = src_addr >> OFF_W;
    word_idx  = idx_full[IDX_W-1:0];
    off       = src_addr[OFF_W-1:0];
    sh_amt    = {off, 3'b000};
    range_err = (idx_full >= 64'(DEPTH));
    size_err  = (nbits > 7'(DATA_W));
    case (src_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = src_addr[0];
      2'd2:    misaligned = |src_addr[1:0];
      default: misaligned = |src_addr[2:0];
    endcase
    dec_err = range_err || size_err || misaligned;

    rd_word = mem[word_idx];
    sh      = rd_word >> sh_amt;
    mask    = (nbits >= 7'(DATA_W)) ? {DATA_W{1'b1}} : ~({DATA_W{1'b1}} << nbits);
    // Top bit of the field is the only bit set in mask but not in mask>>1.
    sign    = |(sh & mask & ~(mask >> 1));
    ld_val  = (sh & mask) | ((src_signed && sign) ? ~mask : '0);

    case (src_size)
      2'd0:    lane = 8'h01;
      2'd1:    lane = 8'h03;
      2'd2:    lane = 8'h0F;
      default: lane = 8'hFF;
    endcase
    be  = lane << off;
    wsh = src_wdata << sh_amt;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_n = DONE;
          end else begin
            state_n = WAIT;
            cnt_n   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          state_n = DONE;
          cnt_n   = 4'd0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_write    <= 1'b0;
      q_size     <= 2'd0;
      q_signed   <= 1'b0;
      q_addr     <= '0;
      q_wdata    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        q_write  <= req_write;
        q_size   <= req_size;
        q_signed <= req_signed;
        q_addr   <= req_addr;
        q_wdata  <= req_wdata;
      end
      if (enter_done) begin
        resp_err   <= dec_err;
        resp_rdata <= (dec_err || src_write) ? '0 : ld_val;
      end
    end
  end

  // A reset landing on the retiring edge must drop the store.
  always_ff @(posedge clk) begin
    if (!reset && state == DONE && q_write && !dec_err) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wsh[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed and randomized checks of data_mem_ctrl against a byte-array model
module tb_data_mem_ctrl;
  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        reset;
  logic        v64, v32;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rdy64, rsp64, err64;
  logic [63:0] rd64;
  logic        rdy32, rsp32, err32;
  logic [31:0] rd32;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  mb [2][0:DEPTH*8-1];
  logic [63:0] last_rd [2];
  logic        last_er [2];

  always #5 clk = ~clk;

  data_mem_ctrl #(.DATA_W(64), .DEPTH(DEPTH), .LATENCY(2), .INIT_PATTERN(1)) dut64 (
    .clk(clk), .reset(reset), .req_valid(v64), .req_ready(rdy64), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rsp64), .resp_rdata(rd64), .resp_err(err64));

  data_mem_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .LATENCY(1), .INIT_PATTERN(1)) dut32 (
    .clk(clk), .reset(reset), .req_valid(v32), .req_ready(rdy32), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .resp_valid(rsp32), .resp_rdata(rd32), .resp_err(err32));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic o_rdy(input int inst); return inst != 0 ? rdy32 : rdy64; endfunction
  function automatic logic o_rsp(input int inst); return inst != 0 ? rsp32 : rsp64; endfunction
  function automatic logic o_err(input int inst); return inst != 0 ? err32 : err64; endfunction
  function automatic logic [63:0] o_rd(input int inst); return inst != 0 ? 64'(rd32) : rd64; endfunction

  task automatic init_model();
    logic [63:0] val;
    for (int inst = 0; inst < 2; inst++) begin
      int wb = (inst != 0) ? 4 : 8;
      for (int i = 0; i < DEPTH; i++) begin
        val = (i == 10) ? 64'd1540 : (i == 11) ? 64'd2117 : 64'(100 * i);
        for (int k = 0; k < wb; k++) mb[inst][i*wb + k] = val[8*k +: 8];
      end
    end
  endtask

  // Byte-array reference: range, alignment and width rules, little-endian assembly.
  task automatic model(input int inst, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [63:0] a, input logic [63:0] wd,
                       output logic [63:0] rd, output logic er);
    int nb = 1 << sz;
    int wb = (inst != 0) ? 4 : 8;
    rd = '0;
    er = (a >= 64'(DEPTH * wb)) || ((a % 64'(nb)) != 0) || (nb > wb);
    if (!er) begin
      if (w) begin
        for (int k = 0; k < nb; k++) mb[inst][int'(a) + k] = wd[8*k +: 8];
      end else begin
        for (int k = 0; k < nb; k++) rd[8*k +: 8] = mb[inst][int'(a) + k];
        if (sg && rd[8*nb-1]) for (int k = nb; k < wb; k++) rd[8*k +: 8] = 8'hFF;
      end
    end
  endtask

  task automatic tx(input int inst, input logic w, input logic [1:0] sz, input logic sg,
                    input logic [63:0] a, input logic [63:0] wd, input string tag,
                    output logic [63:0] ord, output logic oer);
    logic [63:0] erd;
    logic        eer;
    int lat = 0;
    int busy = 0;
    @(negedge clk);
    chk({tag, ":idle_rsp"}, 64'(o_rsp(inst)), 64'd0);
    chk({tag, ":idle_rdy"}, 64'(o_rdy(inst)), 64'd1);
    chk({tag, ":hold_rd"}, o_rd(inst), last_rd[inst]);
    chk({tag, ":hold_err"}, 64'(o_err(inst)), 64'(last_er[inst]));
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    if (inst != 0) v32 = 1'b1; else v64 = 1'b1;
    @(posedge clk);
    #1;
    v64 = 1'b0; v32 = 1'b0;
    req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    do begin
      @(negedge clk);
      lat++;
      if (!o_rdy(inst)) busy++;
    end while (!o_rsp(inst) && lat < 40);
    model(inst, w, sz, sg, a, wd, erd, eer);
    chk({tag, ":lat"}, 64'(lat), (inst != 0) ? 64'd1 : 64'd2);
    chk({tag, ":busy"}, 64'(busy), (inst != 0) ? 64'd1 : 64'd2);
    chk({tag, ":rdata"}, o_rd(inst), erd);
    chk({tag, ":err"}, 64'(o_err(inst)), 64'(eer));
    ord = o_rd(inst);
    oer = o_err(inst);
    last_rd[inst] = erd;
    last_er[inst] = eer;
  endtask

  initial begin
    logic [63:0] rd, erd, a;
    logic        er, eer;
    logic [1:0]  sz;
    logic        w, sg;

    reset = 1'b1; v64 = 1'b0; v32 = 1'b0;
    req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    init_model();
    last_rd[0] = '0; last_rd[1] = '0; last_er[0] = 1'b0; last_er[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy64", 64'(rdy64), 64'd1);
    chk("rst_rsp64", 64'(rsp64), 64'd0);
    chk("rst_rd64", rd64, 64'd0);
    chk("rst_err64", 64'(err64), 64'd0);
    chk("rst_rdy32", 64'(rdy32), 64'd1);
    chk("rst_rsp32", 64'(rsp32), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    tx(0, 0, 3, 0, 64'd80, 0, "ld80", rd, er);
    chk("ld80_const", rd, 64'h604);
    tx(0, 1, 0, 0, 64'd81, 64'hFF, "stb81", rd, er);
    chk("stb81_rd0", rd, 64'd0);
    tx(0, 0, 3, 0, 64'd80, 0, "ld80b", rd, er);
    chk("ld80b_const", rd, 64'hFF04);
    tx(0, 0, 3, 0, 64'd88, 0, "ld88", rd, er);
    chk("ld88_const", rd, 64'd2117);
    tx(0, 0, 0, 1, 64'd81, 0, "lbs81", rd, er);
    chk("lbs81_const", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    tx(0, 0, 0, 0, 64'd81, 0, "lbu81", rd, er);
    chk("lbu81_const", rd, 64'hFF);
    tx(0, 0, 1, 1, 64'd80, 0, "lhs80", rd, er);
    chk("lhs80_const", rd, 64'hFFFF_FFFF_FFFF_FF04);
    tx(0, 0, 1, 0, 64'd81, 0, "lh81_mis", rd, er);
    chk("lh81_err", 64'(er), 64'd1);
    tx(0, 0, 3, 0, 64'd1024, 0, "ld1024", rd, er);
    chk("ld1024_err", 64'(er), 64'd1);
    tx(0, 1, 3, 0, 64'd1024, 64'hDEAD_BEEF_0BAD_F00D, "sd1024", rd, er);
    chk("sd1024_err", 64'(er), 64'd1);
    tx(0, 0, 3, 0, 64'd1016, 0, "ld1016", rd, er);
    chk("ld1016_const", rd, 64'd12700);

    tx(1, 0, 3, 0, 64'd0, 0, "w32_sd", rd, er);
    chk("w32_sd_err", 64'(er), 64'd1);
    tx(1, 0, 2, 0, 64'd40, 0, "w32_lw40", rd, er);
    chk("w32_lw40_const", rd, 64'd1540);
    tx(1, 0, 1, 1, 64'd42, 0, "w32_lh42", rd, er);
    chk("w32_lh42_const", rd, 64'd0);

    // Request held through WAIT with a moving address: only the first is served.
    @(negedge clk);
    req_write = 1'b0; req_size = 2'd3; req_signed = 1'b0; req_addr = 64'd24; v64 = 1'b1;
    @(negedge clk);
    chk("hold_wait_rdy", 64'(rdy64), 64'd0);
    req_addr = 64'd32;
    @(negedge clk);
    model(0, 0, 3, 0, 64'd24, 0, erd, eer);
    chk("hold_first_rsp", 64'(rsp64), 64'd1);
    chk("hold_first_rd", rd64, erd);
    req_addr = 64'd40;
    @(negedge clk);
    chk("hold_idle_rdy", 64'(rdy64), 64'd1);
    chk("hold_idle_rsp", 64'(rsp64), 64'd0);
    @(posedge clk);
    #1;
    v64 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model(0, 0, 3, 0, 64'd40, 0, erd, eer);
    chk("hold_second_rsp", 64'(rsp64), 64'd1);
    chk("hold_second_rd", rd64, erd);
    last_rd[0] = erd; last_er[0] = eer;

    // Reset during WAIT of a store: aborted, no response, nothing written.
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd3; req_addr = 64'd0; req_wdata = 64'h1234; v64 = 1'b1;
    @(posedge clk);
    #1;
    v64 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_rdy", 64'(rdy64), 64'd1);
    chk("mid_rst_rsp", 64'(rsp64), 64'd0);
    chk("mid_rst_rd", rd64, 64'd0);
    chk("mid_rst_err", 64'(err64), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_no_rsp", 64'(rsp64), 64'd0);
    end
    reset = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0; last_er[0] = 1'b0; last_er[1] = 1'b0;
    tx(0, 0, 3, 0, 64'd0, 0, "ld0_after_rst", rd, er);
    chk("ld0_after_rst_const", rd, 64'd0);

    for (int n = 0; n < 60; n++) begin
      w = 1'($urandom); sz = 2'($urandom); sg = 1'($urandom);
      a = 64'($urandom_range(0, 1039));
      if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << sz) - 1);
      if ($urandom_range(0, 15) == 0) a = {$urandom, $urandom};
      tx(0, w, sz, sg, a, {$urandom, $urandom}, "rnd64", rd, er);
    end
    for (int n = 0; n < 30; n++) begin
      w = 1'($urandom); sz = 2'($urandom); sg = 1'($urandom);
      a = 64'($urandom_range(0, 519));
      if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << sz) - 1);
      tx(1, w, sz, sg, a, {$urandom, $urandom}, "rnd32", rd, er);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised successor to the core's flat data RAM. It adds byte addressing, sub-word access sizes (B/H/W/D) with little-endian lane steering, sign/zero extension on loads, and a configurable-latency request/response handshake. It sits between the MEM stage and the data storage array; the stage stalls on req_ready/resp_valid instead of assuming a zero-cycle read.

Parameters:
DATA_W, 64, word width in bits; must be 32 or 64.
DEPTH, 128, number of DATA_W words in the array.
LATENCY, 2, cycles from request accept to resp_valid; legal range 1..15.
INIT_PATTERN, 1, 1 = simulation init (word i = 100*i, word 10 = 1540, word 11 = 2117); 0 = all zero.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-high; clears FSM and outputs; array contents are retained.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request this cycle.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  0 = byte, 1 = half, 2 = word(32), 3 = dword(64).
req_signed  in  1  load only: 1 = sign-extend, 0 = zero-extend.
req_addr  in  64  byte address.
req_wdata  in  DATA_W  store data; low (8<<req_size) bits are used.
resp_valid  out  1  one-cycle pulse: transaction complete.
resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
resp_err  out  1  valid with resp_valid: misaligned, out-of-range, or illegal size.

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, FSM=IDLE, counter=0.
- Request capture: a request is accepted when req_valid && req_ready at a rising edge. On accept, write/size/signed/addr/wdata are registered. Input changes after accept have no effect.
- FSM states:
  - IDLE: req_ready=1. On accept, go to WAIT with cnt = LATENCY-1. If LATENCY=1, go directly to DONE.
  - WAIT: req_ready=0. Decrement cnt each cycle. When cnt reaches 1, go to DONE.
  - DONE: req_ready=0. resp_valid=1 for exactly this cycle. Then go to IDLE.
- Latency: accept at edge N gives resp_valid high in the cycle after edge N+LATENCY-1; back-to-back throughput is one request per LATENCY+1 cycles.
- Address decode:
  - BYTES = DATA_W/8, idx = addr >> log2(BYTES), off = addr mod BYTES.
  - Error if idx >= DEPTH, if addr is not a multiple of (1<<size), or if (8<<size) > DATA_W.
  - Checks use the full 64-bit address; there is no wrap-around.
- Store: committed at the DONE edge. Only bytes off .. off+(1<<size)-1 of word idx are written (little-endian); other bytes are unchanged. Errored stores write nothing.
- Load: the array is read at the DONE transition. The field at byte off of width (8<<size) is right-justified, then sign- or zero-extended to DATA_W. Reading a full-width word with req_signed=1 returns it unchanged.
- Hold behaviour: resp_rdata and resp_err hold their last value after resp_valid drops, and are cleared only by reset or the next DONE.
- Error response: resp_err=1, resp_rdata=0, resp_valid pulses with normal latency.
- req_valid while busy: ignored, not queued; the requester must hold it until req_ready.
- Reset mid-transaction: the transaction is aborted, no resp_valid is issued, and a pending store is not committed. The array keeps its prior contents.
- Array is not reset; INIT_PATTERN is applied once at time zero.

Test Plan:
- Reset, then dword load from addr 80 (word 10), LATENCY=2 -> req_ready low 2 cycles; resp_valid on the 2nd cycle after accept; rdata=1540 (0x604); err=0.
- Byte store 0xFF to addr 81, then dword load from addr 80 -> 0xFF04; neighbouring bytes unchanged; dword load from addr 88 -> 2117.
- Signed byte load from addr 81 -> 0xFFFF_FFFF_FFFF_FFFF; unsigned -> 0xFF. Signed half load from addr 80 -> 0xFFFF_FFFF_FFFF_FF04.
- Error cases: half load from addr 81, dword load from addr 1024 (idx 128), and size=3 with DATA_W=32 -> resp_err=1, rdata=0. A failed store to addr 1024 leaves the array unchanged.
- Hold req_valid through WAIT with a changing req_addr -> only the first request is served; the second is accepted in the IDLE cycle after DONE.
- Assert reset during WAIT of a store of 0x1234 to addr 0 -> no resp_valid, all outputs at reset values; a subsequent load from addr 0 -> 0.
